// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU core: FSM encoding, C-instruction field
// positions and the ALU control bundle.
package hack_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    WAIT_M = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam int A_BIT    = 12;
  localparam int CMP_LSB  = 6;
  localparam int DEST_LSB = 3;
  localparam int JMP_LSB  = 0;

  // Field order matches the instruction word: zx is bit 11, no is bit 6.
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctl_t;

endpackage

// File: rtl/hack_alu.sv
// Combinational N-bit Hack ALU: preset/negate both operands, add or AND,
// optionally negate the result; flags for zero and negative.
module hack_alu
  import hack_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  alu_ctl_t     ctl,
  output logic [N-1:0] out,
  output logic         zr,
  output logic         ng
);

  logic [N-1:0] xz, xn, yz, yn, fo;

  always_comb begin
    xz  = ctl.zx ? '0 : x;
    xn  = ctl.nx ? ~xz : xz;
    yz  = ctl.zy ? '0 : y;
    yn  = ctl.ny ? ~yz : yz;
    fo  = ctl.f ? (xn + yn) : (xn & yn);
    out = ctl.no ? ~fo : fo;
    zr  = (out == '0);
    ng  = out[N-1];
  end

endmodule

// File: rtl/hack_cpu_wait.sv
// Hack CPU core with a data-memory ready handshake, optional stall timeout and
// sticky fault halt. Define HACK_CPU_ICOUNT_EN to add the retired-instruction counter.
module hack_cpu_wait
  import hack_pkg::*;
#(
  parameter int N        = 16,
  parameter int AW       = 15,
  parameter int WAIT_MAX = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  outROM,
  input  logic [N-1:0]  outRAM,
  input  logic          memRdy,
  output logic [N-1:0]  inRAM,
  output logic [AW-1:0] addRAM,
  output logic          enM,
  output logic [AW-1:0] PC,
  output logic          memErr
`ifdef HACK_CPU_ICOUNT_EN
  ,output logic [31:0]  icount
`endif
);

  // Counter only has to hold WAIT_MAX-1; the next stall halts instead.
  localparam int WCW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  state_t         state, state_nxt;
  logic [N-1:0]   a_reg, d_reg;
  logic [WCW-1:0] wait_cnt;

  logic           is_c, a_sel;
  logic [2:0]     dest, jmp;
  alu_ctl_t       ctl;
  logic [N-1:0]   y_op, alu_out;
  logic           zr, ng;
  logic           active, mem_op, stall, timeout, commit, jmp_take;

  assign is_c  = outROM[N-1];
  assign a_sel = outROM[A_BIT];
  assign dest  = outROM[DEST_LSB +: 3];
  assign jmp   = outROM[JMP_LSB +: 3];
  assign ctl   = alu_ctl_t'(outROM[CMP_LSB +: 6]);
  assign y_op  = a_sel ? outRAM : a_reg;

  hack_alu #(.N(N)) u_alu (
    .x   (d_reg),
    .y   (y_op),
    .ctl (ctl),
    .out (alu_out),
    .zr  (zr),
    .ng  (ng)
  );

  assign inRAM  = alu_out;
  assign addRAM = a_reg[AW-1:0];

  always_comb begin
    active    = (state == RUN) || (state == WAIT_M);
    mem_op    = is_c & (a_sel | dest[0]);
    stall     = active & mem_op & ~memRdy;
    timeout   = stall & (WAIT_MAX > 0) & (wait_cnt == WCW'(WAIT_MAX - 1));
    commit    = active & ~stall;
    jmp_take  = is_c & ((jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr));
    enM       = active & is_c & dest[0];
    state_nxt = state;
    case (state)
      BOOT:        state_nxt = RUN;
      RUN, WAIT_M: begin
        if (timeout)    state_nxt = HALT;
        else if (stall) state_nxt = WAIT_M;
        else            state_nxt = RUN;
      end
      HALT:        state_nxt = HALT;
      default:     state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BOOT;
      a_reg    <= '0;
      d_reg    <= '0;
      PC       <= '0;
      wait_cnt <= '0;
      memErr   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (timeout) memErr <= 1'b1;
      if (commit)                      wait_cnt <= '0;
      else if (stall && WAIT_MAX > 0)  wait_cnt <= wait_cnt + 1'b1;
      // Jump target uses the pre-edge A even when A is also a destination.
      if (commit) begin
        if (!is_c) begin
          a_reg <= {1'b0, outROM[N-2:0]};
        end else begin
          if (dest[2]) a_reg <= alu_out;
          if (dest[1]) d_reg <= alu_out;
        end
        PC <= jmp_take ? a_reg[AW-1:0] : PC + 1'b1;
      end
    end
  end

`ifdef HACK_CPU_ICOUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        icount <= '0;
    else if (commit) icount <= icount + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hack_cpu_wait.sv
// Self-checking bench for hack_cpu_wait (N=16, AW=15, WAIT_MAX=4): ROM/RAM
// models, expectation queue drained at the falling edge.
module tb_hack_cpu_wait;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_rdy = 1'b1;
  logic [15:0] out_rom, out_ram, in_ram;
  logic [14:0] add_ram, pc;
  logic        en_m, mem_err;
`ifdef HACK_CPU_ICOUNT_EN
  logic [31:0] icount;
`endif

  logic [15:0] rom [0:32767];
  logic [15:0] ram [0:32767];

  assign out_rom = rom[pc];
  assign out_ram = ram[add_ram];

  always #5 clk = ~clk;

  hack_cpu_wait #(.N(16), .AW(15), .WAIT_MAX(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .outROM (out_rom),
    .outRAM (out_ram),
    .memRdy (mem_rdy),
    .inRAM  (in_ram),
    .addRAM (add_ram),
    .enM    (en_m),
    .PC     (pc),
    .memErr (mem_err)
`ifdef HACK_CPU_ICOUNT_EN
    ,.icount (icount)
`endif
  );

  // RAM write monitor: the RAM accepts a write on an edge with enM and memRdy high.
  int          wr_cnt = 0;
  logic [14:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  always @(posedge clk) begin
    if (rst && en_m && mem_rdy) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= add_ram;
      wr_data <= in_ram;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  localparam int S_PC = 0, S_ADDR = 1, S_EN = 2, S_WDATA = 3, S_ERR = 4, S_ICNT = 5;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_PC:    return {17'd0, pc};
      S_ADDR:  return {17'd0, add_ram};
      S_EN:    return {31'd0, en_m};
      S_WDATA: return {16'd0, in_ram};
      S_ERR:   return {31'd0, mem_err};
`ifdef HACK_CPU_ICOUNT_EN
      S_ICNT:  return icount;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic want(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32768; i++) begin
      rom[i] = 16'h0000;
      ram[i] = 16'h0000;
    end
  endtask

  // Leaves the DUT at a falling edge with BOOT done: state RUN, PC=0.
  task automatic restart();
    rst = 1'b0;
    mem_rdy = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  int base;
  int exp_pc [11] = '{1, 10, 11, 12, 13, 14, 15, 20, 21, 32'h7FFF, 0};

  initial begin
    clear_mem();

    // Reset values while held in reset
    #12;
    want("rst_pc", S_PC, 0); want("rst_addr", S_ADDR, 0);
    want("rst_en", S_EN, 0); want("rst_err", S_ERR, 0);
    drain();

    // Store sequence: @5, D=A, M=D
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'hE308;
    base = wr_cnt;
    @(negedge clk); rst = 1'b1; @(negedge clk);
    want("boot_pc", S_PC, 0); drain();
    cyc(); want("t2_pc1", S_PC, 1); want("t2_en1", S_EN, 0); drain();
    cyc(); want("t2_pc2", S_PC, 2); want("t2_en2", S_EN, 1);
    want("t2_addr", S_ADDR, 5); want("t2_wdata", S_WDATA, 16'h0005); drain();
    cyc(); want("t2_pc3", S_PC, 3); want("t2_en3", S_EN, 0); drain();
    chk("t2_wr_count", wr_cnt - base, 1);
    chk("t2_wr_addr", {17'd0, wr_addr}, 5);
    chk("t2_wr_data", {16'd0, wr_data}, 16'h0005);

    // Load with three stall cycles: @7, D=A, @9, D=M, M=D
    clear_mem();
    rom[0] = 16'h0007; rom[1] = 16'hEC10; rom[2] = 16'h0009;
    rom[3] = 16'hFC10; rom[4] = 16'hE308;
    ram[9] = 16'h1234;
    restart();
    cyc(); cyc(); cyc();
    want("t3_pc", S_PC, 3); want("t3_addr", S_ADDR, 9); drain();
    mem_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      want($sformatf("t3_hold_pc%0d", k), S_PC, 3);
      want($sformatf("t3_hold_en%0d", k), S_EN, 0);
      want($sformatf("t3_hold_err%0d", k), S_ERR, 0);
      drain();
    end
    mem_rdy = 1'b1;
    cyc();
    want("t3_pc_after", S_PC, 4); want("t3_d_loaded", S_WDATA, 16'h1234);
    want("t3_en_after", S_EN, 1); drain();

    // Jumps: JEQ taken/not taken, destA+JMP uses old A, PC wrap
    clear_mem();
    rom[0]  = 16'h000A; rom[1]  = 16'hE302;
    rom[10] = 16'h0001; rom[11] = 16'hEC10; rom[12] = 16'h0014; rom[13] = 16'hE302;
    rom[14] = 16'h0014; rom[15] = 16'hEDE7;
    rom[20] = 16'h7FFF; rom[21] = 16'hEC07;
    rom[32767] = 16'h0003;
    restart();
    for (int k = 0; k < 11; k++) begin
      cyc();
      want($sformatf("t4_pc%0d", k), S_PC, exp_pc[k]);
      if (exp_pc[k] == 20) want("t4_destA_addr", S_ADDR, 21);
      drain();
    end

    // Timeout: M=D with memRdy stuck low
    clear_mem();
    rom[0] = 16'h0005; rom[1] = 16'hE308;
    restart();
    cyc();
    base = wr_cnt;
    mem_rdy = 1'b0;
    want("t5_en_run", S_EN, 1); want("t5_pc_run", S_PC, 1); drain();
    for (int k = 0; k < 3; k++) begin
      cyc();
      want($sformatf("t5_wait_en%0d", k), S_EN, 1);
      want($sformatf("t5_wait_err%0d", k), S_ERR, 0);
      want($sformatf("t5_wait_addr%0d", k), S_ADDR, 5);
      drain();
    end
    cyc();
    want("t5_halt_en", S_EN, 0); want("t5_halt_err", S_ERR, 1); want("t5_halt_pc", S_PC, 1);
    drain();
    mem_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      want($sformatf("t5_frozen_pc%0d", k), S_PC, 1);
      want($sformatf("t5_sticky_err%0d", k), S_ERR, 1);
      want($sformatf("t5_frozen_en%0d", k), S_EN, 0);
      drain();
    end
    chk("t5_no_write", wr_cnt - base, 0);
    #2 rst = 1'b0;
    #1 want("t5_rst_err", S_ERR, 0); want("t5_rst_pc", S_PC, 0); drain();

    // Asynchronous reset in the middle of a wait
    restart();
    cyc();
    base = wr_cnt;
    mem_rdy = 1'b0;
    cyc();
    want("t1_wait_en", S_EN, 1); drain();
    #2 rst = 1'b0;
    #1 want("t1_async_en", S_EN, 0); want("t1_async_pc", S_PC, 0);
    want("t1_async_addr", S_ADDR, 0); want("t1_async_err", S_ERR, 0); drain();
    mem_rdy = 1'b1;
    @(negedge clk); rst = 1'b1;
    cyc(); want("t1_boot_pc", S_PC, 0); drain();
    cyc(); want("t1_run_pc", S_PC, 1); drain();
    chk("t1_no_partial_write", wr_cnt - base, 0);

`ifdef HACK_CPU_ICOUNT_EN
    // Ten retired instructions with two stall cycles
    clear_mem();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'hE308;
    for (int k = 3; k < 10; k++) rom[k] = 16'(k);
    restart();
    want("t6_icnt0", S_ICNT, 0); drain();
    cyc(); cyc();
    mem_rdy = 1'b0;
    cyc(); cyc();
    want("t6_icnt_stall", S_ICNT, 2); drain();
    mem_rdy = 1'b1;
    for (int k = 0; k < 20 && pc != 15'd10; k++) cyc();
    want("t6_pc10", S_PC, 10); want("t6_icnt10", S_ICNT, 10); drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
